gate_net_classifier_seq: RTL and testbench

//  Parametrised, time-multiplexed successor to the fixed combinational MNIST gate-network classifiers.
//  - Evaluates a runtime-loadable table of threshold gates over one binarised image, one gate per cycle.
//  - Popcounts the gate outputs per class and emits the argmax class over a valid/ready handshake.
//  - Sits between the image binariser and the result sink; classes, gates and fan-in are set at elaboration.

---
 rtl/gate_net_classifier_seq_pkg.sv | 42 ++++
 rtl/gate_net_classifier_seq_tgate_eval.sv | 40 ++++
 rtl/gate_net_classifier_seq.sv | 162 ++++++++++++++++
 tb/tb_gate_net_classifier_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_net_classifier_seq_pkg.sv
// rtl/gate_net_classifier_seq_pkg.sv - shared widths, state encoding and gate-entry layout for the gate-network classifier
package gate_net_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_ARGMAX,
    S_DONE
  } state_t;

  // Counter/pointer width that never collapses to zero bits.
  function automatic int w_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int idx_w(input int n_in);
    return $clog2(n_in + 2);
  endfunction

  function automatic int thr_w(input int fanin);
    return w_of(fanin + 1);
  endfunction

  function automatic int entry_w(input int n_in, input int fanin);
    return 1 + thr_w(fanin) + fanin * idx_w(n_in);
  endfunction

  function automatic int score_w(input int gpc);
    return w_of(gpc + 1);
  endfunction

  // Gate entry layout with the default fan-in of 4 and 49 image bits.
  typedef struct packed {
    logic       inv;
    logic [2:0] thr;
    logic [5:0] idx3;
    logic [5:0] idx2;
    logic [5:0] idx1;
    logic [5:0] idx0;
  } gate_entry_default_t;

endpackage

// File: rtl/gate_net_classifier_seq_tgate_eval.sv
// rtl/gate_net_classifier_seq_tgate_eval.sv - one threshold gate: source mux, popcount, compare, invert
module tgate_eval
  import gate_net_pkg::*;
#(
  parameter  int N_IN    = 49,
  parameter  int FANIN   = 4,
  localparam int IDX_W   = idx_w(N_IN),
  localparam int THR_W   = thr_w(FANIN),
  localparam int ENTRY_W = entry_w(N_IN, FANIN)
) (
  input  logic [N_IN-1:0]    bits,
  input  logic [ENTRY_W-1:0] entry,
  output logic               gate
);

  localparam int SRC_N = 1 << IDX_W;

  logic [SRC_N-1:0] src;
  logic [IDX_W-1:0] idx;
  logic [THR_W-1:0] s;
  logic [THR_W-1:0] thr;
  logic             inv;

  // Source N_IN is tied high, N_IN+1 and every unused code read as 0.
  always_comb begin
    src            = '0;
    src[N_IN-1:0]  = bits;
    src[N_IN]      = 1'b1;
    thr            = entry[FANIN*IDX_W +: THR_W];
    inv            = entry[ENTRY_W-1];
    s              = '0;
    idx            = '0;
    for (int k = 0; k < FANIN; k++) begin
      idx = entry[k*IDX_W +: IDX_W];
      s   = s + THR_W'(src[idx]);
    end
    gate = (s >= thr) ^ inv;
  end

endmodule

// File: rtl/gate_net_classifier_seq.sv
// rtl/gate_net_classifier_seq.sv - time-multiplexed threshold-gate classifier with per-class vote and argmax
module gate_net_classifier_seq
  import gate_net_pkg::*;
#(
  parameter  int N_IN    = 49,
  parameter  int N_CLASS = 2,
  parameter  int GPC     = 16,
  parameter  int FANIN   = 4,
  localparam int G_TOT   = N_CLASS * GPC,
  localparam int ENTRY_W = entry_w(N_IN, FANIN),
  localparam int SCORE_W = score_w(GPC),
  localparam int CLS_W   = $clog2(N_CLASS),
  // One spare code above the table so out-of-range writes stay observable.
  localparam int ADDR_W  = $clog2(G_TOT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_bits,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_data,
  output logic               cfg_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLS_W-1:0]   out_class,
  output logic [N_CLASS-1:0] out_bits,
  output logic [SCORE_W-1:0] out_score
);

  localparam int GP_W  = w_of(G_TOT);
  localparam int SUB_W = w_of(GPC);

  localparam logic [ADDR_W-1:0]  ADDR_LIM  = ADDR_W'(G_TOT);
  localparam logic [GP_W-1:0]    GPTR_LAST = GP_W'(G_TOT - 1);
  localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(GPC - 1);
  localparam logic [CLS_W-1:0]   CLS_LAST  = CLS_W'(N_CLASS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(GPC);

  state_t             state;
  logic [N_IN-1:0]    img;
  logic [ENTRY_W-1:0] gate_tab [G_TOT];
  logic [SCORE_W-1:0] cnt [N_CLASS];
  logic [GP_W-1:0]    gptr;
  logic [SUB_W-1:0]   sub;
  logic [CLS_W-1:0]   cls_ptr;
  logic [CLS_W-1:0]   cidx;
  logic [CLS_W-1:0]   best_cls;
  logic [SCORE_W-1:0] best_score;
  logic [CLS_W-1:0]   win_cls;
  logic [SCORE_W-1:0] win_score;
  logic               gate;

  tgate_eval #(
    .N_IN  (N_IN),
    .FANIN (FANIN)
  ) u_gate (
    .bits  (img),
    .entry (gate_tab[gptr]),
    .gate  (gate)
  );

  // Strict greater-than keeps the lowest class index on a tie.
  always_comb begin
    win_cls   = best_cls;
    win_score = best_score;
    if (cnt[cidx] > best_score) begin
      win_cls   = cidx;
      win_score = cnt[cidx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_class  <= '0;
      out_bits   <= '0;
      out_score  <= '0;
      cfg_err    <= 1'b0;
      img        <= '0;
      gptr       <= '0;
      sub        <= '0;
      cls_ptr    <= '0;
      cidx       <= '0;
      best_cls   <= '0;
      best_score <= '0;
      for (int c = 0; c < N_CLASS; c++) cnt[c] <= '0;
      for (int g = 0; g < G_TOT; g++) gate_tab[g] <= '0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (state == S_IDLE && cfg_addr < ADDR_LIM) begin
          gate_tab[cfg_addr[GP_W-1:0]] <= cfg_data;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            img        <= in_bits;
            gptr       <= '0;
            sub        <= '0;
            cls_ptr    <= '0;
            best_cls   <= '0;
            best_score <= '0;
            for (int c = 0; c < N_CLASS; c++) cnt[c] <= '0;
            in_ready   <= 1'b0;
            state      <= S_EVAL;
          end
        end

        S_EVAL: begin
          if (gate && cnt[cls_ptr] < SCORE_MAX) begin
            cnt[cls_ptr] <= cnt[cls_ptr] + SCORE_W'(1);
          end
          if (gptr == GPTR_LAST) begin
            cidx  <= '0;
            state <= S_ARGMAX;
          end else begin
            gptr <= gptr + GP_W'(1);
            if (sub == SUB_LAST) begin
              sub     <= '0;
              cls_ptr <= cls_ptr + CLS_W'(1);
            end else begin
              sub <= sub + SUB_W'(1);
            end
          end
        end

        S_ARGMAX: begin
          best_cls   <= win_cls;
          best_score <= win_score;
          if (cidx == CLS_LAST) begin
            out_class <= win_cls;
            out_score <= win_score;
            out_bits  <= N_CLASS'(1) << win_cls;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cidx <= cidx + CLS_W'(1);
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_net_classifier_seq.sv
// tb/tb_gate_net_classifier_seq.sv - randomized scoreboard bench for gate_net_classifier_seq
module tb_gate_net_classifier_seq;

  localparam int N_IN    = 49;
  localparam int N_CLASS = 2;
  localparam int GPC     = 4;
  localparam int FANIN   = 2;
  localparam int G_TOT   = N_CLASS * GPC;
  localparam int LAT     = G_TOT + N_CLASS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [48:0] in_bits = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [14:0] cfg_data = '0;
  logic        cfg_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [0:0]  out_class;
  logic [1:0]  out_bits;
  logic [2:0]  out_score;

  gate_net_classifier_seq #(
    .N_IN    (N_IN),
    .N_CLASS (N_CLASS),
    .GPC     (GPC),
    .FANIN   (FANIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_bits  (out_bits),
    .out_score (out_score)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int m_inv [G_TOT];
  int m_thr [G_TOT];
  int m_i0  [G_TOT];
  int m_i1  [G_TOT];

  typedef struct {
    int cls;
    int sc;
    int acc;
  } exp_t;
  exp_t sb[$];
  logic prev_v = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int srcb(input logic [48:0] im, input int i);
    if (i < N_IN) return int'(im[i]);
    if (i == N_IN) return 1;
    return 0;
  endfunction

  function automatic void model(input logic [48:0] im, output int cls, output int sc);
    int cnt [N_CLASS];
    int s;
    for (int c = 0; c < N_CLASS; c++) cnt[c] = 0;
    for (int g = 0; g < G_TOT; g++) begin
      s = srcb(im, m_i0[g]) + srcb(im, m_i1[g]);
      if (((s >= m_thr[g]) ? 1 : 0) != m_inv[g]) cnt[g / GPC]++;
    end
    cls = 0;
    sc  = cnt[0];
    for (int c = 1; c < N_CLASS; c++) begin
      if (cnt[c] > sc) begin
        cls = c;
        sc  = cnt[c];
      end
    end
  endfunction

  function automatic logic [14:0] pack(input int inv, input int thr, input int i0, input int i1);
    return {inv[0], thr[1:0], i1[5:0], i0[5:0]};
  endfunction

  function automatic logic [48:0] rand_img();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[48:0];
  endfunction

  function automatic void model_set(input int a, input int inv, input int thr, input int i0, input int i1);
    m_inv[a] = inv;
    m_thr[a] = thr;
    m_i0[a]  = i0;
    m_i1[a]  = i1;
  endfunction

  // Scoreboard monitor: latency on the rising edge of out_valid, result on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got out_valid=1 expected no pending result");
        end else begin
          chk("latency", cyc - sb[0].acc, LAT);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got handshake expected none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_class", int'(out_class), e.cls);
          chk("out_score", int'(out_score), e.sc);
          chk("out_bits", int'(out_bits), 1 << e.cls);
        end
      end
      prev_v <= out_valid;
    end
  end

  task automatic cfg_write(input int addr, input int inv, input int thr, input int i0, input int i1,
                           input int exp_err);
    @(posedge clk);
    #1;
    cfg_we   = 1'b1;
    cfg_addr = addr[3:0];
    cfg_data = pack(inv, thr, i0, i1);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    chk("cfg_err", int'(cfg_err), exp_err);
    if (exp_err != 0) begin
      @(posedge clk);
      #1;
      chk("cfg_err_clear", int'(cfg_err), 0);
    end else begin
      model_set(addr, inv, thr, i0, i1);
    end
  endtask

  // mode 0: plain, 1: rejected write during EVAL, 2: write on the accept edge
  task automatic run_image(input logic [48:0] im, input int hold, input int mode);
    int   cls, sc, n, a, inv, thr, i0, i1;
    exp_t e;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 100 cycles");
      return;
    end
    in_bits  = im;
    in_valid = 1'b1;
    if (mode == 2) begin
      a   = $urandom_range(0, G_TOT - 1);
      inv = $urandom_range(0, 1);
      thr = $urandom_range(0, 3);
      i0  = $urandom_range(0, 63);
      i1  = $urandom_range(0, 63);
      cfg_we   = 1'b1;
      cfg_addr = a[3:0];
      cfg_data = pack(inv, thr, i0, i1);
      model_set(a, inv, thr, i0, i1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    in_bits  = rand_img();
    model(im, cls, sc);
    e.cls = cls;
    e.sc  = sc;
    e.acc = cyc;
    sb.push_back(e);
    if (mode == 2) chk("cfg_err_same_edge", int'(cfg_err), 0);
    if (mode == 1) begin
      cfg_we   = 1'b1;
      cfg_addr = 4'($urandom_range(0, G_TOT - 1));
      cfg_data = 15'($urandom());
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      chk("cfg_err_eval", int'(cfg_err), 1);
      @(posedge clk);
      #1;
      chk("cfg_err_pulse", int'(cfg_err), 0);
    end
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got out_valid=0 expected 1 within 100 cycles");
      void'(sb.pop_back());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_class", int'(out_class), cls);
      chk("hold_score", int'(out_score), sc);
      chk("hold_bits", int'(out_bits), 1 << cls);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_valid", int'(out_valid), 0);
  endtask

  task automatic load_case2();
    for (int g = 0; g < GPC; g++) cfg_write(g, 0, 1, 50, 50, 0);
    for (int g = GPC; g < G_TOT; g++) cfg_write(g, 0, 2, 0, 1, 0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no finish expected completion before time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n;
    for (int g = 0; g < G_TOT; g++) model_set(g, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_class", int'(out_class), 0);
    chk("rst_out_bits", int'(out_bits), 0);
    chk("rst_out_score", int'(out_score), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);

    run_image('0, 0, 0);
    run_image(rand_img(), 0, 0);

    load_case2();
    run_image(49'b11, 0, 0);
    run_image(49'b01, 0, 0);

    for (int g = 0; g < GPC; g++) cfg_write(g, 1, 1, 50, 50, 0);
    run_image(49'b11, 0, 0);

    run_image(49'b11, 20, 0);

    load_case2();
    run_image(49'b11, 0, 1);
    run_image(49'b11, 0, 0);
    cfg_write(8, 1, 0, 0, 0, 1);
    cfg_write(15, 1, 0, 0, 0, 1);
    run_image(49'b11, 0, 0);

    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(0, 3);
      for (int w = 0; w < n; w++) begin
        cfg_write($urandom_range(0, G_TOT - 1), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 63), $urandom_range(0, 63), 0);
      end
      run_image(rand_img(), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    load_case2();
    run_image(49'b11, 0, 0);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_bits  = rand_img();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_class", int'(out_class), 0);
    chk("abort_out_bits", int'(out_bits), 0);
    chk("abort_out_score", int'(out_score), 0);
    for (int g = 0; g < G_TOT; g++) model_set(g, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_image(rand_img(), 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
